// File: rtl/bit_seq_tx.sv
// bit_seq_tx - serial bit-pattern transmitter.
//
// Latches an N-bit pattern and shifts the low `length` bits out MSB-first, one
// bit per clock, with out_valid marking frame bits. The frame can be repeated
// `repeat_cnt` extra times, with GAP_CYCLES idle cycles between frames. SEG shows
// the number of frame bits still to come, as a 7-segment code.
//
// Ports
//   clk_2       in   clock
//   reset_n     in   asynchronous active-low reset
//   start       in   begin transmission (honoured only while idle)
//   abort       in   synchronous cancel; has priority over start
//   pattern     in   frame data; bits [len-1:0] are sent, bit len-1 first
//   length      in   frame length; 0 or a value above NBITS_PAT means NBITS_PAT
//   repeat_cnt  in   extra repeats (total frames = repeat_cnt+1). The name
//                    "repeat" is a reserved word, so the port carries this name.
//   out_bit     out  serial data, 0 whenever out_valid is 0
//   out_valid   out  out_bit carries a frame bit this cycle
//   busy        out  transmitter is not idle
//   done        out  one-cycle pulse after the final bit of the final frame
//   bits_left   out  frame bits still to appear after the current one
//   SEG         out  7-segment code of bits_left[3:0] (dp = bit 7 = 0)
//   dbg_state   out  current FSM state (debug observation)
//
// Handshake: start is a level sampled on each rising edge; it is accepted only
// when the FSM is idle and abort is low. No acknowledge is returned other than
// busy rising on the accepting edge.
module bit_seq_tx #(
  parameter int NBITS_PAT  = 8,
  parameter int NBITS_LEN  = $clog2(NBITS_PAT) + 1,
  parameter int NBITS_REP  = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk_2,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NBITS_PAT-1:0] pattern,
  input  logic [NBITS_LEN-1:0] length,
  input  logic [NBITS_REP-1:0] repeat_cnt,
  output logic                 out_bit,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done,
  output logic [NBITS_LEN-1:0] bits_left,
  output logic [7:0]           SEG,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_GAP = 2'd2} state_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TOP   = NBITS_PAT - 1;

  state_t                 state_q, state_d;
  logic [NBITS_PAT-1:0]   pat_q, pat_d;   // latched frame, MSB-aligned
  logic [NBITS_PAT-1:0]   sh_q, sh_d;     // bits after the one on out_bit
  logic [NBITS_LEN-1:0]   len_q, len_d;
  logic [NBITS_REP-1:0]   reps_q, reps_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   out_bit_q, out_bit_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NBITS_LEN-1:0]   bits_left_q, bits_left_d;

  logic [NBITS_LEN-1:0]   eff_len;
  logic [NBITS_PAT-1:0]   aligned;

  // Frame bits are moved to the top of the register so the serializer always
  // takes the MSB, independent of the frame length.
  always_comb begin
    eff_len = length;
    if (length == '0 || length > NBITS_LEN'(NBITS_PAT)) eff_len = NBITS_LEN'(NBITS_PAT);
    aligned = pattern << (NBITS_LEN'(NBITS_PAT) - eff_len);
  end

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    sh_d        = sh_q;
    len_d       = len_q;
    reps_d      = reps_q;
    gap_d       = gap_q;
    out_bit_d   = 1'b0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    bits_left_d = bits_left_q;

    case (state_q)
      ST_IDLE: begin
        bits_left_d = '0;
        if (start) begin
          pat_d       = aligned;
          len_d       = eff_len;
          reps_d      = repeat_cnt;
          out_bit_d   = aligned[TOP];
          sh_d        = aligned << 1;
          out_valid_d = 1'b1;
          bits_left_d = eff_len - 1'b1;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bits_left_q != '0) begin
          out_bit_d   = sh_q[TOP];
          sh_d        = sh_q << 1;
          out_valid_d = 1'b1;
          bits_left_d = bits_left_q - 1'b1;
        end else if (reps_q == '0) begin
          state_d     = ST_IDLE;
          done_d      = 1'b1;
          bits_left_d = '0;
        end else begin
          reps_d = reps_q - 1'b1;
          if (GAP_CYCLES == 0) begin
            // Back-to-back frames: first bit follows bit 0 directly.
            out_bit_d   = pat_q[TOP];
            sh_d        = pat_q << 1;
            out_valid_d = 1'b1;
            bits_left_d = len_q - 1'b1;
          end else begin
            state_d     = ST_GAP;
            gap_d       = GAP_W'(GAP_CYCLES - 1);
            bits_left_d = len_q;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          out_bit_d   = pat_q[TOP];
          sh_d        = pat_q << 1;
          out_valid_d = 1'b1;
          bits_left_d = len_q - 1'b1;
          state_d     = ST_SEND;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d     = ST_IDLE;
      out_bit_d   = 1'b0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      bits_left_d = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pat_q       <= '0;
      sh_q        <= '0;
      len_q       <= '0;
      reps_q      <= '0;
      gap_q       <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bits_left_q <= '0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      sh_q        <= sh_d;
      len_q       <= len_d;
      reps_q      <= reps_d;
      gap_q       <= gap_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bits_left_q <= bits_left_d;
    end
  end

  always_comb begin
    case (4'(bits_left_q))
      4'h0: SEG = 8'h3F;
      4'h1: SEG = 8'h06;
      4'h2: SEG = 8'h5B;
      4'h3: SEG = 8'h4F;
      4'h4: SEG = 8'h66;
      4'h5: SEG = 8'h6D;
      4'h6: SEG = 8'h7D;
      4'h7: SEG = 8'h07;
      4'h8: SEG = 8'h7F;
      4'h9: SEG = 8'h6F;
      4'hA: SEG = 8'h77;
      4'hB: SEG = 8'h7C;
      4'hC: SEG = 8'h58;
      4'hD: SEG = 8'h5E;
      4'hE: SEG = 8'h79;
      default: SEG = 8'h71;
    endcase
  end

  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bits_left = bits_left_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bit_seq_tx.sv
// Bench for bit_seq_tx: two instances (GAP_CYCLES=2 and GAP_CYCLES=0) share
// one stimulus stream. For each, a transcript model expands an accepted start
// into the full list of per-cycle outputs it must produce; a compare process
// checks every cycle, and directed sections pin literal expectations.
module tb_bit_seq_tx;

  logic       clk_2 = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] length = '0;
  logic [3:0] repeat_v = '0;

  logic       ob2, ov2, bz2, dn2, ob0, ov0, bz0, dn0;
  logic [3:0] bl2, bl0;
  logic [7:0] seg2, seg0;
  logic [1:0] st2, st0;

  int total = 0;
  int bad = 0;

  always #5 clk_2 = ~clk_2;

  bit_seq_tx #(.NBITS_PAT(8), .NBITS_REP(4), .GAP_CYCLES(2)) dut2 (
    .clk_2(clk_2), .reset_n(reset_n), .start(start), .abort(abort),
    .pattern(pattern), .length(length), .repeat_cnt(repeat_v),
    .out_bit(ob2), .out_valid(ov2), .busy(bz2), .done(dn2),
    .bits_left(bl2), .SEG(seg2), .dbg_state(st2));

  bit_seq_tx #(.NBITS_PAT(8), .NBITS_REP(4), .GAP_CYCLES(0)) dut0 (
    .clk_2(clk_2), .reset_n(reset_n), .start(start), .abort(abort),
    .pattern(pattern), .length(length), .repeat_cnt(repeat_v),
    .out_bit(ob0), .out_valid(ov0), .busy(bz0), .done(dn0),
    .bits_left(bl0), .SEG(seg0), .dbg_state(st0));

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic       v;
    logic       b;
    logic       bz;
    logic       d;
    logic [3:0] bl;
  } ent_t;
  typedef ent_t ent_q_t[$];

  logic [7:0] seg_tab [0:15] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h58, 8'h5E, 8'h79, 8'h71};

  ent_q_t exp_q2, exp_q0;
  ent_t   exp2 = '0;
  ent_t   exp0 = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic ent_t mk(input logic v, input logic b, input logic bz,
                              input logic d, input logic [3:0] bl);
    ent_t e;
    e.v = v; e.b = b; e.bz = bz; e.d = d; e.bl = bl;
    return e;
  endfunction

  // Whole transcript of one transmission, one entry per cycle after the
  // accepting edge, ending with the done cycle.
  function automatic ent_q_t build(input int gap, input logic [7:0] pat,
                                   input logic [3:0] len_in, input logic [3:0] rep);
    ent_q_t q;
    int L;
    L = (len_in == 0 || len_in > 8) ? 8 : int'(len_in);
    for (int f = 0; f <= int'(rep); f++) begin
      for (int i = L - 1; i >= 0; i--) q.push_back(mk(1'b1, pat[i], 1'b1, 1'b0, 4'(i)));
      if (f < int'(rep))
        for (int g = 0; g < gap; g++) q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'(L)));
    end
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd0));
    return q;
  endfunction

  always @(posedge clk_2) begin
    if (!reset_n || abort) begin
      exp_q2.delete(); exp_q0.delete();
      exp2 = '0; exp0 = '0;
    end else begin
      if (exp_q2.size() == 0 && start) exp_q2 = build(2, pattern, length, repeat_v);
      if (exp_q0.size() == 0 && start) exp_q0 = build(0, pattern, length, repeat_v);
      exp2 = (exp_q2.size() != 0) ? exp_q2.pop_front() : ent_t'('0);
      exp0 = (exp_q0.size() != 0) ? exp_q0.pop_front() : ent_t'('0);
    end
  end

  always @(negedge clk_2) begin
    if (reset_n) begin
      chk("g2_out", 32'({ov2, ob2, bz2, dn2, bl2}), 32'(exp2));
      chk("g2_seg", 32'(seg2), 32'(seg_tab[exp2.bl]));
      chk("g0_out", 32'({ov0, ob0, bz0, dn0, bl0}), 32'(exp0));
      chk("g0_seg", 32'(seg0), 32'(seg_tab[exp0.bl]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk_2);
  endtask

  task automatic start_tx(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
    pattern = p; length = l; repeat_v = r; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && (bz2 || bz0 || dn2 || dn0); i++) tick();
    chk("idle_wait", 32'({bz2, bz0, dn2, dn0}), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  int   s07 [3] = '{8'h5B, 8'h06, 8'h3F};
  int   a5b [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  int   n, seen, busy_c2, val_c2, done_c2, busy_c0, val_c0, done_c0, run0, maxrun0;

  initial begin
    tick(); tick();
    chk("rst_out2", 32'({ob2, ov2, bz2, dn2, bl2}), 32'd0);
    chk("rst_seg2", 32'(seg2), 32'h3F);
    #2 reset_n = 1'b1;
    tick();

    // 3-bit frame of 8'h07
    start_tx(8'h07, 4'd3, 4'd0);
    for (int i = 0; i < 3; i++) begin
      chk("p07_bit", 32'({ov2, ob2}), 32'b11);
      chk("p07_left", 32'(bl2), 32'(2 - i));
      chk("p07_seg", 32'(seg2), 32'(s07[i]));
      tick();
    end
    chk("p07_done", 32'({dn2, bz2, ov2}), 32'b100);
    tick();
    chk("p07_after", 32'({dn2, bz2}), 32'b00);
    wait_idle();

    // length 0 means full width
    start_tx(8'hA5, 4'd0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      chk("a5_bit", 32'(ob2), 32'(a5b[i]));
      chk("a5_left", 32'(bl2), 32'(7 - i));
      tick();
    end
    wait_idle();

    // 3 frames of 1101, gap 2 vs gap 0
    start_tx(8'h0D, 4'd4, 4'd2);
    pattern = 8'hFF; length = 4'd7; repeat_v = 4'd9;  // must not matter while busy
    n = 0; seen = 0; busy_c2 = 0; val_c2 = 0; done_c2 = 0;
    busy_c0 = 0; val_c0 = 0; done_c0 = 0; run0 = 0; maxrun0 = 0;
    while (!seen && n < 100) begin
      busy_c2 += int'(bz2); val_c2 += int'(ov2); done_c2 += int'(dn2);
      busy_c0 += int'(bz0); val_c0 += int'(ov0); done_c0 += int'(dn0);
      run0 = ov0 ? run0 + 1 : 0;
      if (run0 > maxrun0) maxrun0 = run0;
      if (dn2) seen = 1;
      tick(); n++;
    end
    chk("gap_seen_done", 32'(seen), 32'd1);
    chk("gap2_busy", 32'(busy_c2), 32'd16);
    chk("gap2_valid", 32'(val_c2), 32'd12);
    chk("gap2_done", 32'(done_c2), 32'd1);
    chk("gap0_busy", 32'(busy_c0), 32'd12);
    chk("gap0_run", 32'(maxrun0), 32'd12);
    chk("gap0_done", 32'(done_c0), 32'd1);
    wait_idle();

    // abort on the 3rd bit, start while busy ignored
    start_tx(8'h96, 4'd8, 4'd1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_out", 32'({ov2, bz2, dn2, bl2}), 32'd0);
    done_c2 = 0;
    for (int i = 0; i < 6; i++) begin done_c2 += int'(dn2); tick(); end
    chk("abort_nodone", 32'(done_c2), 32'd0);

    // abort with start in idle stays idle
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", 32'({ov2, bz2}), 32'd0);

    // asynchronous reset mid-frame
    start_tx(8'hC3, 4'd8, 4'd2);
    tick(); tick();
    #1 reset_n = 1'b0;
    #1;
    chk("arst_out2", 32'({ob2, ov2, bz2, dn2, bl2}), 32'd0);
    chk("arst_seg2", 32'(seg2), 32'h3F);
    chk("arst_out0", 32'({ob0, ov0, bz0, dn0, bl0}), 32'd0);
    tick();
    #2 reset_n = 1'b1;
    tick();

    // random traffic, scoreboard checks every cycle
    for (int c = 0; c < 1500; c++) begin
      start    = ($urandom_range(0, 3) == 0);
      abort    = ($urandom_range(0, 29) == 0);
      pattern  = 8'($urandom);
      length   = 4'($urandom_range(0, 11));
      repeat_v = 4'($urandom_range(0, 3));
      tick();
    end
    start = 1'b0; abort = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
